// File: rtl/l1_writeback_ctrl_if.sv
// Bus bundle for the L1 write-back controller: the cache line-select port
// (line_sel / line_data / line_addr / line_status) and the memory write
// request/acknowledge handshake.
interface l1_writeback_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned IDX_W  = 2
);
  logic [IDX_W-1:0]  line_sel;
  logic [DATA_W-1:0] line_data;
  logic [ADDR_W-1:0] line_addr;
  logic [1:0]        line_status;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;

  // Controller side
  modport master (
    output line_sel, mem_req, mem_addr, mem_data,
    input  line_data, line_addr, line_status, mem_ack
  );

  // Cache / memory side
  modport slave (
    input  line_sel, mem_req, mem_addr, mem_data,
    output line_data, line_addr, line_status, mem_ack
  );
endinterface

// File: rtl/l1_writeback_ctrl.sv
// L1 write-back controller. On a flush request, scans every cache line via the
// line-select port, writes modified lines (status 2'b00) back to memory over a
// req/ack handshake, and reports each cleaned line index.
// Optional macro WB_TIMEOUT_EN: abandon a write-back after TIMEOUT cycles
// without ack and raise a sticky err flag. Without it, WB waits indefinitely.
module l1_writeback_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned LINES   = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  l1_writeback_ctrl_if.master  bus_io,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 clean_valid_o,
  output logic [IDX_W-1:0]     clean_idx_o,
  output logic [2:0]           wb_count_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {StIdle, StScan, StWb, StDone} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clean_valid_q, clean_valid_d;
  logic [IDX_W-1:0]  clean_idx_q, clean_idx_d;
  logic [2:0]        wb_count_q, wb_count_d;
  logic              last_line;
  logic              advance;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign last_line = (idx_q == IDX_W'(LINES - 1));

  // Next-state and registered-output logic for the flush sequencer
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    clean_valid_d = 1'b0;
    clean_idx_d   = clean_idx_q;
    wb_count_d    = wb_count_q;
    advance       = 1'b0;
`ifdef WB_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_d         = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d      = '0;
          wb_count_d = '0;
          state_d    = StScan;
        end
      end
      StScan: begin
        // Any status other than a definite 2'b00 (including X/Z) is skipped
        if (bus_io.line_status == 2'b00) begin
          mem_addr_d = bus_io.line_addr;
          mem_data_d = bus_io.line_data;
          mem_req_d  = 1'b1;
          state_d    = StWb;
`ifdef WB_TIMEOUT_EN
          tmo_d      = '0;
`endif
        end else begin
          advance = 1'b1;
        end
      end
      StWb: begin
        if (bus_io.mem_ack) begin
          mem_req_d     = 1'b0;
          wb_count_d    = wb_count_q + 3'd1;
          clean_valid_d = 1'b1;
          clean_idx_d   = idx_q;
          advance       = 1'b1;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          // Give up on this line: no clean report, no count
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          advance   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Shared step to the next line; the last line always exits to DONE
    if (advance) begin
      if (last_line) begin
        state_d = StDone;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StScan;
      end
    end

    done_d = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset aborts any flush immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      clean_valid_q <= 1'b0;
      clean_idx_q   <= '0;
      wb_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      clean_valid_q <= clean_valid_d;
      clean_idx_q   <= clean_idx_d;
      wb_count_q    <= wb_count_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  // Ack wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign bus_io.line_sel = idx_q;
  assign bus_io.mem_req  = mem_req_q;
  assign bus_io.mem_addr = mem_addr_q;
  assign bus_io.mem_data = mem_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign clean_valid_o   = clean_valid_q;
  assign clean_idx_o     = clean_idx_q;
  assign wb_count_o      = wb_count_q;

endmodule

// File: tb/tb_l1_writeback_ctrl.sv
// Scoreboard bench for l1_writeback_ctrl: stimulus pushes expected write-backs,
// clean reports and done pulses; a monitor pops and compares them as they appear.
module tb_l1_writeback_ctrl;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int LINES   = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 15;

  typedef struct {
    int addr;
    int data;
    int len;
  } wb_t;

  typedef struct {
    int cnt;
    int cyc;
  } done_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, clean_valid, err;
  logic [IDX_W-1:0] clean_idx;
  logic [2:0]       wb_count;

  logic [1:0]        c_status[LINES];
  logic [ADDR_W-1:0] c_addr[LINES];
  logic [DATA_W-1:0] c_data[LINES];

  wb_t   wb_q[$];
  int    clean_q[$];
  done_t done_q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int ack_delay = 1;  // 0 = never ack
  bit ack_tie = 1'b0;

  l1_writeback_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  l1_writeback_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .bus_io       (bus),
    .busy_o       (busy),
    .done_o       (done),
    .clean_valid_o(clean_valid),
    .clean_idx_o  (clean_idx),
    .wb_count_o   (wb_count),
    .err_o        (err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cache model: line-select port answers combinationally
  always_comb begin
    bus.line_status = c_status[bus.line_sel];
    bus.line_addr   = c_addr[bus.line_sel];
    bus.line_data   = c_data[bus.line_sel];
  end

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Memory responder: ack after mem_req has been seen for ack_delay cycles
  initial begin
    int hold = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        hold++;
        bus.mem_ack = (ack_delay != 0) && (hold >= ack_delay);
      end else begin
        hold = 0;
        bus.mem_ack = ack_tie;
      end
    end
  end

  // Monitor: compares every DUT output event against the queued expectations
  initial begin
    bit    prev_req = 1'b0;
    int    hold = 0;
    wb_t   cur;
    done_t d;
    cur = '{addr: 0, data: 0, len: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        hold = 0;
      end else begin
        if (bus.mem_req) begin
          if (!prev_req) begin
            check("wb_expected", int'(wb_q.size() > 0), 1);
            if (wb_q.size() > 0) cur = wb_q.pop_front();
            check("wb_addr", int'(bus.mem_addr), cur.addr);
            check("wb_data", int'(bus.mem_data), cur.data);
            hold = 1;
          end else begin
            hold++;
            check("wb_addr_stable", int'(bus.mem_addr), cur.addr);
            check("wb_data_stable", int'(bus.mem_data), cur.data);
          end
        end else if (prev_req) begin
          check("wb_req_cycles", hold, cur.len);
        end
        prev_req = bus.mem_req;

        if (clean_valid) begin
          check("clean_expected", int'(clean_q.size() > 0), 1);
          if (clean_q.size() > 0) check("clean_idx", int'(clean_idx), clean_q.pop_front());
        end

        if (done) begin
          check("done_expected", int'(done_q.size() > 0), 1);
          if (done_q.size() > 0) begin
            d = done_q.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("done_wb_count", int'(wb_count), d.cnt);
            check("done_busy", int'(busy), 1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_line(input int i, input logic [1:0] st, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] dt);
    c_status[i] = st;
    c_addr[i]   = a;
    c_data[i]   = dt;
  endtask

  task automatic all_clean();
    for (int i = 0; i < LINES; i++) set_line(i, 2'b11, '0, '0);
  endtask

  // Returns the posedge count of the edge that accepted start
  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  // Builds expectations from the cache contents, then runs one flush
  task automatic run_flush(input int delay, input bit tmo);
    int lat = LINES + 1;
    int cnt = 0;
    int s;
    ack_delay = delay;
    for (int i = 0; i < LINES; i++) begin
      if (c_status[i] == 2'b00) begin
        if (tmo) begin
          wb_q.push_back('{addr: int'(c_addr[i]), data: int'(c_data[i]), len: TIMEOUT});
          lat += TIMEOUT;
        end else begin
          wb_q.push_back('{addr: int'(c_addr[i]), data: int'(c_data[i]), len: delay});
          clean_q.push_back(i);
          cnt++;
          lat += delay;
        end
      end
    end
    pulse_start(s);
    done_q.push_back('{cnt: cnt, cyc: s + lat - 1});
    wait_idle();
  endtask

  initial begin
    int s;
    int n;
    all_clean();
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_mem_req", int'(bus.mem_req), 0);
    check("rst_done", int'(done), 0);
    check("rst_wb_count", int'(wb_count), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_line_sel", int'(bus.line_sel), 0);
    check("idle_clean_valid", int'(clean_valid), 0);
    check("idle_err", int'(err), 0);

    // T1: all lines clean
    run_flush(1, 1'b0);

    // T2: line 0 modified, ack tied high
    set_line(0, 2'b00, 3'b001, 8'b10101010);
    ack_tie = 1'b1;
    run_flush(1, 1'b0);
    ack_tie = 1'b0;
    check("t2_wb_count_hold", int'(wb_count), 1);

    // T3: lines 0 and 2 modified, ack after 3 cycles each
    all_clean();
    set_line(0, 2'b00, 3'b001, 8'b11111111);
    set_line(2, 2'b00, 3'b111, 8'b00001111);
    run_flush(3, 1'b0);
    check("t3_wb_count_hold", int'(wb_count), 2);

    // T4: mixed statuses, last line modified; extra start while busy is ignored
    set_line(0, 2'b01, 3'd4, 8'h11);
    set_line(1, 2'b10, 3'd6, 8'h22);
    set_line(2, 2'b11, 3'd2, 8'h33);
    set_line(3, 2'b00, 3'd5, 8'h3C);
    ack_delay = 2;
    wb_q.push_back('{addr: 5, data: 8'h3C, len: 2});
    clean_q.push_back(3);
    pulse_start(s);
    done_q.push_back('{cnt: 1, cyc: s + LINES + 2});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_mid", int'(busy), 1);
    wait_idle();
    run_flush(2, 1'b0);

    // T4b: start held high through DONE restarts on the first IDLE edge
    all_clean();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    s = cyc;
    done_q.push_back('{cnt: 0, cyc: s + LINES});
    done_q.push_back('{cnt: 0, cyc: s + 6 + LINES});
    n = 0;
    while (cyc < s + 6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("t4b_restart_busy", int'(busy), 1);
    wait_idle();

    // T5: asynchronous reset during WB
    set_line(1, 2'b00, 3'd2, 8'h55);
    ack_delay = 0;
    wb_q.push_back('{addr: 2, data: 8'h55, len: 0});
    pulse_start(s);
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_req_seen", int'(bus.mem_req), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_mem_req", int'(bus.mem_req), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_line_sel", int'(bus.line_sel), 0);
    check("t5_mem_addr", int'(bus.mem_addr), 0);
    check("t5_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_idle_after", int'(busy), 0);

`ifdef WB_TIMEOUT_EN
    // T6: ack never arrives, write-back abandoned after TIMEOUT cycles
    all_clean();
    set_line(2, 2'b00, 3'd3, 8'h81);
    ack_delay = 0;
    run_flush(0, 1'b1);
    check("t6_err", int'(err), 1);
    check("t6_wb_count", int'(wb_count), 0);
`else
    check("err_tied_low", int'(err), 0);
`endif

    check("wb_q_drained", wb_q.size(), 0);
    check("clean_q_drained", clean_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_writeback_ctrl.md
Name: l1_writeback_ctrl

Overview:
Downstream bus-side stage of the 4-line L1 cache.
- On a flush request, scans every cache line through the cache's line-select bus port (localAddrIn / dOutBus / addrOut / statusOut).
- Writes each modified line (status 2'b00) back to main memory over a req/ack handshake.
- Reports each cleaned line index so the cache can downgrade that line's status.

Parameters:
DATA_W, 8, data width of a cache line and the memory word
ADDR_W, 3, memory address width (matches cache addrOut)
LINES, 4, number of cache lines scanned per flush
IDX_W, 2, line index width, equal to log2(LINES)
TIMEOUT, 15, ack wait limit in cycles; used only with WB_TIMEOUT_EN

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  flush request; sampled only in IDLE
line_sel  output  IDX_W  line index driven to the cache localAddrIn
line_data  input  DATA_W  cache dOutBus for line_sel
line_addr  input  ADDR_W  cache addrOut for line_sel
line_status  input  2  cache statusOut for line_sel
mem_req  output  1  write-back request to memory
mem_addr  output  ADDR_W  write-back address
mem_data  output  DATA_W  write-back data
mem_ack  input  1  memory accepted the write
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when a flush completes
clean_valid  output  1  one-cycle pulse: line clean_idx was written back
clean_idx  output  IDX_W  index of the cleaned line
wb_count  output  3  number of lines written back in the current/last flush
err  output  1  sticky timeout flag (WB_TIMEOUT_EN only)

Behaviour:
- Clock: clk. Reset: rst, asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; idx 0.
- Reset mid-flush aborts immediately: mem_req drops asynchronously; no done pulse.
- All outputs are registered.
- Line status: 2'b00 = modified, needs write-back. 2'b01, 2'b10, 2'b11, and any X/Z = skip, no write-back.
- States: IDLE, SCAN, WB, DONE.
- IDLE:
  - On an edge with start=1: idx<=0, line_sel<=0, wb_count<=0, go SCAN.
  - start is ignored in every other state; no queuing.
- SCAN:
  - line_sel = idx has been stable for a full cycle.
  - At the edge, capture line_addr and line_data into holding regs.
  - If line_status==2'b00: go WB, with mem_req<=1, mem_addr/mem_data<=captured values.
  - Else if idx==LINES-1: go DONE.
  - Else: idx<=idx+1, line_sel<=idx+1, stay in SCAN.
  - Cost: 1 cycle per clean line.
- WB:
  - mem_req, mem_addr and mem_data are held stable until an edge with mem_ack=1.
  - On that edge:
    - mem_req<=0; wb_count<=wb_count+1.
    - clean_valid<=1 for exactly the next cycle, with clean_idx<=idx.
    - Then advance exactly as SCAN would (next idx, or DONE after the last line).
  - Minimum 2 cycles per modified line (SCAN + WB with immediate ack).
- mem_ack while mem_req=0 is ignored.
- DONE: done=1 for one cycle, busy still 1; next state IDLE.
- idx never wraps within a flush: the last line always exits to DONE.
- wb_count max is LINES (4) and fits in 3 bits; it holds its value after DONE until the next start.
- Flush latency: LINES + (sum of WB cycles) + 1 DONE cycle after start is accepted.
  - Example: all lines clean = start edge, then 4 SCAN cycles, then DONE; done rises 5 cycles after the start edge.
- start held high through DONE: a new flush begins on the first IDLE edge after DONE.

Optional Feature:
WB_TIMEOUT_EN
- Defined:
  - A counter runs in WB.
  - If mem_ack has not arrived after TIMEOUT cycles: drop mem_req, set err<=1 (sticky until rst), skip the line (no clean_valid, no wb_count increment), and advance as normal.
- Not defined: WB waits indefinitely; err is tied to 0.

Test Plan:
1. All four lines status 2'b11, start pulse -> no mem_req; done pulses 5 cycles after the start edge; wb_count=0.
2. Line 0 status 00, addr 001, data 10101010; mem_ack tied 1 -> one mem_req cycle with mem_addr=001, mem_data=10101010; clean_valid with clean_idx=0; wb_count=1; done.
3. Lines 0 and 2 modified (addr 001 data 11111111; addr 111 data 00001111); ack delayed 3 cycles each -> mem_req held stable 3 cycles each; clean_idx 0 then 2; wb_count=2.
4. start pulsed again while busy -> ignored; exactly one done pulse; second flush starts only after IDLE.
5. rst asserted asynchronously during WB -> mem_req, busy and outputs 0 immediately; no done pulse.
6. WB_TIMEOUT_EN with mem_ack held 0, one modified line -> mem_req drops after 15 cycles; err=1; wb_count=0; done still pulses.
